// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: bundles the CPU MEM-stage port, the host/loader
// port and the data-memory macro port seen by dmem_port_arbiter.
// The slave modport is the arbiter's view. The master modport is the
// surrounding environment's view (pipeline, host and memory macro).
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    // CPU MEM-stage port
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    // Host / boot-loader port
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    // Data-memory macro port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-port synchronous data memory
// between the CPU MEM stage and the host/loader port. The arbiter grants
// at most one access per cycle. The grant is combinational. A read
// response is routed back to its requester one cycle after issue.
// Build option DMEM_ARB_RR_EN: when defined, simultaneous requests are
// arbitrated round-robin. When undefined, the CPU has fixed priority and
// a starvation counter forces a host grant after STARVE_LIMIT denials.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clock,
    input  logic               reset,
    dmem_port_arbiter_if.slave bus
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_HOST = 2'd2;

    logic       cpu_gnt_s;
    logic       host_gnt_s;
    logic [1:0] rd_owner_d;
    logic [1:0] rd_owner_q;

`ifdef DMEM_ARB_RR_EN
    // rr_last: 1'b1 when the host took the most recent grant, 1'b0 when the CPU did
    localparam logic LAST_CPU  = 1'b0;
    localparam logic LAST_HOST = 1'b1;
    logic rr_last_d;
    logic rr_last_q;
`else
    localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt_d;
    logic [3:0] starve_cnt_q;
`endif

    // Pick this cycle's winner. Requests are ignored while reset is asserted.
    always_comb begin
        cpu_gnt_s  = 1'b0;
        host_gnt_s = 1'b0;
        if (reset) begin
            cpu_gnt_s  = 1'b0;
            host_gnt_s = 1'b0;
        end else begin
            case ({bus.cpu_req, bus.host_req})
                2'b10: cpu_gnt_s  = 1'b1;
                2'b01: host_gnt_s = 1'b1;
                2'b11: begin
`ifdef DMEM_ARB_RR_EN
                    if (rr_last_q == LAST_HOST) begin
                        cpu_gnt_s = 1'b1;
                    end else begin
                        host_gnt_s = 1'b1;
                    end
`else
                    if (starve_cnt_q == STARVE_LIM_C) begin
                        host_gnt_s = 1'b1;
                    end else begin
                        cpu_gnt_s = 1'b1;
                    end
`endif
                end
                default: begin
                    cpu_gnt_s  = 1'b0;
                    host_gnt_s = 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Remember which requester was granted last. The value holds when no grant is issued.
    always_comb begin
        rr_last_d = rr_last_q;
        if (cpu_gnt_s) begin
            rr_last_d = LAST_CPU;
        end else if (host_gnt_s) begin
            rr_last_d = LAST_HOST;
        end else begin
            rr_last_d = rr_last_q;
        end
    end
`else
    // Count consecutive denied host cycles. The count saturates at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.host_req || host_gnt_s) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != STARVE_LIM_C) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end
`endif

    // Record who owns the read response returning next cycle. A write records NONE.
    always_comb begin
        rd_owner_d = OWN_NONE;
        if (cpu_gnt_s && !bus.cpu_we) begin
            rd_owner_d = OWN_CPU;
        end else if (host_gnt_s && !bus.host_we) begin
            rd_owner_d = OWN_HOST;
        end else begin
            rd_owner_d = OWN_NONE;
        end
    end

    // Arbitration state registers. Reset drops any pending read response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_owner_q <= OWN_NONE;
`ifdef DMEM_ARB_RR_EN
            rr_last_q  <= LAST_HOST;
`else
            starve_cnt_q <= 4'd0;
`endif
        end else begin
            rd_owner_q <= rd_owner_d;
`ifdef DMEM_ARB_RR_EN
            rr_last_q  <= rr_last_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    // Steer the winner's operands to the memory. Address and data are zero when idle.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (cpu_gnt_s) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (host_gnt_s) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.host_we;
            bus.mem_addr  = bus.host_addr;
            bus.mem_wdata = bus.host_wdata;
        end else begin
            bus.mem_en    = 1'b0;
            bus.mem_we    = 1'b0;
            bus.mem_addr  = '0;
            bus.mem_wdata = '0;
        end
    end

    // Drive the requester-side handshakes. Each rdata output is zero unless its rvalid is high.
    always_comb begin
        bus.cpu_stall   = bus.cpu_req & ~cpu_gnt_s & ~reset;
        bus.host_gnt    = host_gnt_s;
        bus.cpu_rvalid  = (rd_owner_q == OWN_CPU);
        bus.host_rvalid = (rd_owner_q == OWN_HOST);
        bus.cpu_rdata   = '0;
        bus.host_rdata  = '0;
        if (rd_owner_q == OWN_CPU) begin
            bus.cpu_rdata = bus.mem_rdata;
        end else if (rd_owner_q == OWN_HOST) begin
            bus.host_rdata = bus.mem_rdata;
        end else begin
            bus.cpu_rdata  = '0;
            bus.host_rdata = '0;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed self-checking bench for dmem_port_arbiter.
// Behavioural model of the synchronous single-port data memory.
// Inputs are driven 1 ns after each rising edge. Outputs are checked on the falling edge.
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 64;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [DATA_W-1:0] mem [256];

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_LIMIT(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous memory model: a write updates the array, a read result appears after the edge
    always @(posedge clock) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [7:0] addr, input logic [63:0] wd);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    endtask

    task automatic set_host(input logic req, input logic we, input logic [7:0] addr, input logic [63:0] wd);
        bus.host_req = req; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wd;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_mem_en"}, 64'(bus.mem_en), 64'd0);
        chk({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
        chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 64'd0);
        chk({tag, "_cpu_stall"}, 64'(bus.cpu_stall), 64'd0);
        chk({tag, "_host_gnt"}, 64'(bus.host_gnt), 64'd0);
        chk({tag, "_cpu_rvalid"}, 64'(bus.cpu_rvalid), 64'd0);
        chk({tag, "_host_rvalid"}, 64'(bus.host_rvalid), 64'd0);
        chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 64'd0);
        chk({tag, "_host_rdata"}, bus.host_rdata, 64'd0);
    endtask

    initial begin
        logic exp_hg;
        logic exp_crv;
        logic exp_hrv;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 64'd0;
        mem[20] = 64'd17;
        bus.mem_rdata = 64'd0;
        reset = 1'b1;
        // Both ports request while reset is held; the requests must be ignored
        set_cpu(1'b1, 1'b0, 8'd20, 64'd0);
        set_host(1'b1, 1'b0, 8'd22, 64'd0);
        @(negedge clock);
        chk_idle("in_reset");
        next_cycle();
        reset = 1'b0;
        set_cpu(1'b0, 1'b0, 8'd0, 64'd0);
        set_host(1'b0, 1'b0, 8'd0, 64'd0);

        // Both ports idle for a window of cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk_idle("idle");
            next_cycle();
        end

        // CPU LDUR of address 20
        set_cpu(1'b1, 1'b0, 8'd20, 64'd0);
        @(negedge clock);
        chk("ldur_mem_en", 64'(bus.mem_en), 64'd1);
        chk("ldur_mem_we", 64'(bus.mem_we), 64'd0);
        chk("ldur_mem_addr", 64'(bus.mem_addr), 64'd20);
        chk("ldur_stall", 64'(bus.cpu_stall), 64'd0);
        chk("ldur_rvalid_early", 64'(bus.cpu_rvalid), 64'd0);
        next_cycle();
        set_cpu(1'b0, 1'b0, 8'd0, 64'd0);
        @(negedge clock);
        chk("ldur_rvalid", 64'(bus.cpu_rvalid), 64'd1);
        chk("ldur_rdata", bus.cpu_rdata, 64'd17);
        chk("ldur_host_rvalid", 64'(bus.host_rvalid), 64'd0);
        next_cycle();
        @(negedge clock);
        chk("ldur_rvalid_drop", 64'(bus.cpu_rvalid), 64'd0);
        chk("ldur_rdata_zero", bus.cpu_rdata, 64'd0);
        next_cycle();

        // Host writes 6 to address 22, then the CPU reads address 22 in the next cycle
        set_host(1'b1, 1'b1, 8'd22, 64'd6);
        @(negedge clock);
        chk("hwr_gnt", 64'(bus.host_gnt), 64'd1);
        chk("hwr_mem_we", 64'(bus.mem_we), 64'd1);
        chk("hwr_mem_addr", 64'(bus.mem_addr), 64'd22);
        chk("hwr_mem_wdata", bus.mem_wdata, 64'd6);
        next_cycle();
        set_host(1'b0, 1'b0, 8'd0, 64'd0);
        set_cpu(1'b1, 1'b0, 8'd22, 64'd0);
        @(negedge clock);
        chk("raw_host_gnt_off", 64'(bus.host_gnt), 64'd0);
        chk("raw_mem_addr", 64'(bus.mem_addr), 64'd22);
        chk("raw_no_rvalid_after_wr", 64'(bus.host_rvalid | bus.cpu_rvalid), 64'd0);
        next_cycle();
        set_cpu(1'b0, 1'b0, 8'd0, 64'd0);
        @(negedge clock);
        chk("raw_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd1);
        chk("raw_cpu_rdata", bus.cpu_rdata, 64'd6);
        next_cycle();

        // CPU STUR of 9 to address 30, then a host read of address 30
        set_cpu(1'b1, 1'b1, 8'd30, 64'd9);
        @(negedge clock);
        chk("stur_mem_we", 64'(bus.mem_we), 64'd1);
        chk("stur_mem_wdata", bus.mem_wdata, 64'd9);
        next_cycle();
        set_cpu(1'b0, 1'b0, 8'd0, 64'd0);
        set_host(1'b1, 1'b0, 8'd30, 64'd0);
        @(negedge clock);
        chk("hrd_gnt", 64'(bus.host_gnt), 64'd1);
        chk("hrd_cpu_rvalid_after_wr", 64'(bus.cpu_rvalid), 64'd0);
        next_cycle();
        set_host(1'b0, 1'b0, 8'd0, 64'd0);
        @(negedge clock);
        chk("hrd_rvalid", 64'(bus.host_rvalid), 64'd1);
        chk("hrd_rdata", bus.host_rdata, 64'd9);
        chk("hrd_cpu_rdata_zero", bus.cpu_rdata, 64'd0);
        next_cycle();

        // Contention: CPU reads 20 (17), host reads 22 (6), both continuously for 10 cycles.
        // Fixed priority: host wins cycles 5 and 10. Round robin: last grant was the host, so the CPU wins first.
        set_cpu(1'b1, 1'b0, 8'd20, 64'd0);
        set_host(1'b1, 1'b0, 8'd22, 64'd0);
        exp_crv = 1'b0;
        exp_hrv = 1'b0;
        for (int i = 1; i <= 10; i++) begin
`ifdef DMEM_ARB_RR_EN
            exp_hg = ((i % 2) == 0);
`else
            exp_hg = ((i % 5) == 0);
`endif
            @(negedge clock);
            chk($sformatf("both_host_gnt_%0d", i), 64'(bus.host_gnt), 64'(exp_hg));
            chk($sformatf("both_cpu_stall_%0d", i), 64'(bus.cpu_stall), 64'(exp_hg));
            chk($sformatf("both_mem_addr_%0d", i), 64'(bus.mem_addr), exp_hg ? 64'd22 : 64'd20);
            chk($sformatf("both_cpu_rvalid_%0d", i), 64'(bus.cpu_rvalid), 64'(exp_crv));
            chk($sformatf("both_host_rvalid_%0d", i), 64'(bus.host_rvalid), 64'(exp_hrv));
            chk($sformatf("both_cpu_rdata_%0d", i), bus.cpu_rdata, exp_crv ? 64'd17 : 64'd0);
            chk($sformatf("both_host_rdata_%0d", i), bus.host_rdata, exp_hrv ? 64'd6 : 64'd0);
            exp_crv = ~exp_hg;
            exp_hrv = exp_hg;
            next_cycle();
        end
        set_cpu(1'b0, 1'b0, 8'd0, 64'd0);
        set_host(1'b0, 1'b0, 8'd0, 64'd0);
        @(negedge clock);
        chk("both_tail_host_rvalid", 64'(bus.host_rvalid), 64'(exp_hrv));
        chk("both_tail_cpu_rvalid", 64'(bus.cpu_rvalid), 64'(exp_crv));
        chk("both_tail_mem_en", 64'(bus.mem_en), 64'd0);
        next_cycle();

        // Host read of 20 issues, then reset is asserted in the following cycle
        set_host(1'b1, 1'b0, 8'd20, 64'd0);
        @(negedge clock);
        chk("rst_rd_issue_gnt", 64'(bus.host_gnt), 64'd1);
        next_cycle();
        reset = 1'b1;
        @(negedge clock);
        chk_idle("rst_mid_read");
        next_cycle();
        reset = 1'b0;
        // The host is still requesting, so it is granted in the first cycle after reset
        @(negedge clock);
        chk("rst_release_rvalid", 64'(bus.host_rvalid), 64'd0);
        chk("rst_release_gnt", 64'(bus.host_gnt), 64'd1);
        chk("rst_release_mem_addr", 64'(bus.mem_addr), 64'd20);
        next_cycle();
        set_host(1'b0, 1'b0, 8'd0, 64'd0);
        @(negedge clock);
        chk("rst_after_rvalid", 64'(bus.host_rvalid), 64'd1);
        chk("rst_after_rdata", bus.host_rdata, 64'd17);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
